div_seq_32by16: RTL



---
 rtl/div_pkg.sv | 19 +
 rtl/div_restoring_step.sv | 30 +++
 rtl/div_seq_32by16.sv | 136 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the sequential restoring divider.
//   state_e  : divider FSM state (IDLE accepting, RUN iterating, DONE holding)
//   DW_DEF   : default divisor/quotient/remainder width (dividend is 2*DW_DEF)
//   CNT_W_DEF: step-counter width for the default DW
// ---------------------------------------------------------------------------
package div_pkg;

  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned CNT_W_DEF = $clog2(DW_DEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage : div_pkg

// File: rtl/div_restoring_step.sv
// ---------------------------------------------------------------------------
// div_restoring_step
// One combinational radix-2 restoring division step.
//   rem_i     : partial remainder going in (always < divisor_i)
//   bit_i     : next dividend bit, MSB first
//   divisor_i : divisor
//   rem_o     : partial remainder after the step
//   q_o       : quotient bit produced by the step
// ---------------------------------------------------------------------------
module div_restoring_step #(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] rem_i,
  input  logic          bit_i,
  input  logic [DW-1:0] divisor_i,
  output logic [DW-1:0] rem_o,
  output logic          q_o
);

  // Trial value needs one extra bit; the result fits back in DW bits
  // because rem_i < divisor_i keeps the new remainder below the divisor.
  logic [DW:0] trial;
  logic [DW:0] dvs_ext;

  assign trial   = {rem_i, bit_i};
  assign dvs_ext = {1'b0, divisor_i};
  assign q_o     = (trial >= dvs_ext);
  assign rem_o   = DW'(q_o ? (trial - dvs_ext) : trial);

endmodule : div_restoring_step

// File: rtl/div_seq_32by16.sv
// ---------------------------------------------------------------------------
// div_seq_32by16
// Sequential radix-2 restoring divider: 2*DW-bit dividend by DW-bit divisor,
// one step per clock, one division in flight, valid/ready on both sides.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready high only in IDLE)
//   dividend, divisor     : unsigned operands, sampled on the acceptance edge
//   out_valid / out_ready : result handshake, result held until accepted
//   quotient, remainder   : unsigned results
//   div_by_zero, overflow : error flags (quotient forced to all ones)
// ---------------------------------------------------------------------------
module div_seq_32by16
  import div_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int unsigned CNT_W = (DW > 1) ? $clog2(DW) : 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    dvd_q;   // low dividend bits; quotient bits fill in from the LSB
  logic [DW-1:0]    dvs_q;
  logic [DW-1:0]    rem_q;

  logic [DW-1:0]    rem_d;
  logic             qbit_d;
  logic [DW-1:0]    dvd_d;
  logic [DW-1:0]    dvd_hi;

  assign dvd_hi = dividend[2*DW-1:DW];

  // Ready depends on state alone, so no input reaches an output combinationally.
  assign in_ready = (state_q == S_IDLE);

  // Single restoring step on the current partial remainder.
  div_restoring_step #(
    .DW (DW)
  ) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[DW-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_d),
    .q_o       (qbit_d)
  );

  // Dividend bits leave at the MSB while quotient bits enter at the LSB,
  // so after DW steps the shift register holds the full quotient.
  assign dvd_d = {dvd_q[DW-2:0], qbit_d};

  // Divider FSM with counter, operand/working registers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            dvd_q <= dividend[DW-1:0];
            dvs_q <= divisor;
            rem_q <= dvd_hi;
            cnt_q <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[DW-1:0];
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              out_valid   <= 1'b1;
              state_q     <= S_DONE;
            end else if (dvd_hi >= divisor) begin
              // High half already >= divisor: quotient cannot fit in DW bits.
              quotient    <= '1;
              remainder   <= dividend[DW-1:0];
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              out_valid   <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_RUN;
            end
          end
        end

        S_RUN: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DW - 1)) begin
            quotient    <= dvd_d;
            remainder   <= rem_d;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            out_valid   <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_DONE: begin
          // Data outputs keep their values after the result is taken.
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= S_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule : div_seq_32by16
